cordic_rotator_seq: RTL

- Sequential rotation-mode CORDIC: rotates the vector (x_in, y_in) by the angle angle_in, given in degrees.
- It is the consumer end of the arctangent LUT. The block drives the LUT address each iteration and reads atan(2^-i) in degrees, unsigned, 6 integer + 10 fractional bits.
- Used by the sin/cos generation path, the inverse of the vectoring-mode angle estimator.
- One micro-rotation per clock. No gain compensation; the caller applies 1/K.

---
 rtl/cordic_pkg.sv | 24 ++
 rtl/cordic_rotator_seq_if.sv | 29 ++
 rtl/cordic_microrot.sv | 41 ++++
 rtl/cordic_rotator_seq.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared definitions for the sequential rotation-mode CORDIC:
// FSM encoding, default widths and fixed-point angle constants.
package cordic_pkg;

    localparam int XY_W_DEF  = 16;
    localparam int ANG_W_DEF = 19;
    localparam int NITER_DEF = 16;
    localparam int ROM_W_DEF = 16;
    localparam int ITER_W    = 4;

    // Angles are degrees with 10 fractional bits.
    localparam int DEG90  = 92160;
    localparam int DEG180 = 184320;

    // Aggregate CORDIC gain left in the outputs; the caller removes it.
    localparam real CORDIC_K = 1.64676;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_DONE = 2'd2
    } cordic_state_e;

endpackage

// File: rtl/cordic_rotator_seq_if.sv
// Request/result bundle for the CORDIC rotator: operands and start in,
// busy/done status and rotated vector out.
interface cordic_rotator_seq_if
    import cordic_pkg::*;
#(
    parameter int XY_W  = XY_W_DEF,
    parameter int ANG_W = ANG_W_DEF
) ();

    logic                     start;
    logic signed [XY_W-1:0]   x_in;
    logic signed [XY_W-1:0]   y_in;
    logic signed [ANG_W-1:0]  angle_in;
    logic                     busy;
    logic                     done;
    logic signed [XY_W+1:0]   x_out;
    logic signed [XY_W+1:0]   y_out;

    modport master (
        output start, x_in, y_in, angle_in,
        input  busy, done, x_out, y_out
    );

    modport slave (
        input  start, x_in, y_in, angle_in,
        output busy, done, x_out, y_out
    );

endinterface

// File: rtl/cordic_microrot.sv
// One combinational CORDIC micro-rotation in rotation mode: the sign of the
// residual angle z picks the direction, x/y are shifted by the iteration
// index and the LUT arctangent is removed from z.
module cordic_microrot
    import cordic_pkg::*;
#(
    parameter int XW    = XY_W_DEF + 2,
    parameter int ANG_W = ANG_W_DEF,
    parameter int ROM_W = ROM_W_DEF
) (
    input  logic signed [XW-1:0]    x,
    input  logic signed [XW-1:0]    y,
    input  logic signed [ANG_W-1:0] z,
    input  logic [ITER_W-1:0]       i,
    input  logic [ROM_W-1:0]        atan,
    output logic signed [XW-1:0]    x_nx,
    output logic signed [XW-1:0]    y_nx,
    output logic signed [ANG_W-1:0] z_nx
);

    logic signed [XW-1:0]    x_sh_s;
    logic signed [XW-1:0]    y_sh_s;
    logic signed [ANG_W-1:0] atan_s;

    // Rotate towards z = 0; z >= 0 means d = +1.
    always_comb begin
        x_sh_s = x >>> i;
        y_sh_s = y >>> i;
        atan_s = $signed({{(ANG_W - ROM_W){1'b0}}, atan});
        if (z[ANG_W-1] == 1'b0) begin
            x_nx = x - y_sh_s;
            y_nx = y + x_sh_s;
            z_nx = z - atan_s;
        end else begin
            x_nx = x + y_sh_s;
            y_nx = y - x_sh_s;
            z_nx = z + atan_s;
        end
    end

endmodule

// File: rtl/cordic_rotator_seq.sv
// Sequential rotation-mode CORDIC: one micro-rotation per clock, folding
// angles beyond +/-90 degrees by a half-turn pre-rotation. Results carry the
// CORDIC gain K; the arctangent LUT lives outside and is addressed each cycle.
module cordic_rotator_seq
    import cordic_pkg::*;
#(
    parameter int XY_W  = XY_W_DEF,
    parameter int ANG_W = ANG_W_DEF,
    parameter int NITER = NITER_DEF,
    parameter int ROM_W = ROM_W_DEF
) (
    input  logic                  clock,
    input  logic                  reset,
    cordic_rotator_seq_if.slave   bus,
    output logic [ITER_W-1:0]     rom_addr,
    input  logic [ROM_W-1:0]      rom_data
);

    localparam int XW = XY_W + 2;
    localparam logic [ITER_W-1:0]       ITER_LAST = ITER_W'(NITER - 1);
    localparam logic signed [ANG_W-1:0] DEG90_A   = ANG_W'(DEG90);
    localparam logic signed [ANG_W-1:0] DEG180_A  = ANG_W'(DEG180);

    cordic_state_e           state_r;
    cordic_state_e           state_s;
    logic signed [XW-1:0]    x_r;
    logic signed [XW-1:0]    y_r;
    logic signed [ANG_W-1:0] z_r;
    logic [ITER_W-1:0]       iter_r;
    logic                    busy_r;
    logic                    done_r;
    logic signed [XW-1:0]    x_out_r;
    logic signed [XW-1:0]    y_out_r;

    logic signed [XW-1:0]    x_ext_s;
    logic signed [XW-1:0]    y_ext_s;
    logic signed [XW-1:0]    x_ld_s;
    logic signed [XW-1:0]    y_ld_s;
    logic signed [ANG_W-1:0] z_ld_s;
    logic signed [XW-1:0]    x_nx_s;
    logic signed [XW-1:0]    y_nx_s;
    logic signed [ANG_W-1:0] z_nx_s;

    cordic_microrot #(
        .XW    (XW),
        .ANG_W (ANG_W),
        .ROM_W (ROM_W)
    ) u_microrot (
        .x    (x_r),
        .y    (y_r),
        .z    (z_r),
        .i    (iter_r),
        .atan (rom_data),
        .x_nx (x_nx_s),
        .y_nx (y_nx_s),
        .z_nx (z_nx_s)
    );

    // Pre-rotation by 180 degrees keeps the residual angle inside the
    // +/-99.9 degree convergence range of the iterations.
    always_comb begin
        x_ext_s = XW'(bus.x_in);
        y_ext_s = XW'(bus.y_in);
        if (bus.angle_in > DEG90_A) begin
            x_ld_s = -x_ext_s;
            y_ld_s = -y_ext_s;
            z_ld_s = bus.angle_in - DEG180_A;
        end else if (bus.angle_in < -DEG90_A) begin
            x_ld_s = -x_ext_s;
            y_ld_s = -y_ext_s;
            z_ld_s = bus.angle_in + DEG180_A;
        end else begin
            x_ld_s = x_ext_s;
            y_ld_s = y_ext_s;
            z_ld_s = bus.angle_in;
        end
    end

    // Next-state logic: IDLE -> ITER for NITER cycles -> DONE -> IDLE.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    state_s = ST_ITER;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ITER: begin
                if (iter_r == ITER_LAST) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_ITER;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // State register with registered busy/done derived from the next state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s != ST_IDLE);
            done_r  <= (state_s == ST_DONE);
        end
    end

    // Working x/y/z, iteration index (doubles as LUT address) and results.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            x_r     <= '0;
            y_r     <= '0;
            z_r     <= '0;
            iter_r  <= '0;
            x_out_r <= '0;
            y_out_r <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.start) begin
                        x_r    <= x_ld_s;
                        y_r    <= y_ld_s;
                        z_r    <= z_ld_s;
                        iter_r <= '0;
                    end
                end
                ST_ITER: begin
                    x_r <= x_nx_s;
                    y_r <= y_nx_s;
                    z_r <= z_nx_s;
                    if (iter_r == ITER_LAST) begin
                        iter_r  <= '0;
                        x_out_r <= x_nx_s;
                        y_out_r <= y_nx_s;
                    end else begin
                        iter_r <= iter_r + 4'd1;
                    end
                end
                ST_DONE: iter_r <= '0;
                default: iter_r <= '0;
            endcase
        end
    end

    assign rom_addr  = iter_r;
    assign bus.busy  = busy_r;
    assign bus.done  = done_r;
    assign bus.x_out = x_out_r;
    assign bus.y_out = y_out_r;

endmodule
